// File: rtl/sdram_model_param_if.sv
// Command/address bus of the parametrised SDR SDRAM model.
// The controller drives it (master); the device model samples it (slave).
interface sdram_model_param_if #(
    parameter int unsigned DQ_W   = 16,
    parameter int unsigned ROW_W  = 13,
    parameter int unsigned BANK_W = 2
);
    logic              cke;
    logic              cs;
    logic              ras;
    logic              cas;
    logic              we;
    logic [ROW_W-1:0]  a;
    logic [BANK_W-1:0] ba;
    logic [DQ_W/8-1:0] dqm;

    modport master (output cke, cs, ras, cas, we, a, ba, dqm);
    modport slave  (input  cke, cs, ras, cas, we, a, ba, dqm);
endinterface

// File: rtl/sdram_model_param.sv
// Behavioural SDR SDRAM device: per-bank open rows, CL read pipeline, DQM, burst control.
// Define SDRAM_CHECK_EN to enable the sticky protocol checker on err.
module sdram_model_param #(
    parameter int unsigned DQ_W   = 16,
    parameter int unsigned ROW_W  = 13,
    parameter int unsigned COL_W  = 9,
    parameter int unsigned BANK_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    sdram_model_param_if.slave bus,
    inout  wire  [DQ_W-1:0]    dq,
    output logic               err
);
    localparam int unsigned NL    = DQ_W / 8;
    localparam int unsigned NB    = 1 << BANK_W;
    localparam int unsigned AW    = BANK_W + ROW_W + COL_W;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        CmdLoadMode  = 3'b000,
        CmdRefresh   = 3'b001,
        CmdPrecharge = 3'b010,
        CmdActive    = 3'b011,
        CmdWrite     = 3'b100,
        CmdRead      = 3'b101,
        CmdTerminate = 3'b110,
        CmdNop       = 3'b111
    } cmd_e;

    logic [DQ_W-1:0] mem [DEPTH];

    logic [NB-1:0]     open_q;
    logic [ROW_W-1:0]  row_q [NB];

    logic              cl3_q;
    logic [2:0]        bl_code_q;
    logic              wb_single_q;

    // Column generator: words still to issue after the current one
    logic [COL_W-1:0]  gen_left_q;
    logic [COL_W-1:0]  gen_col_q;
    logic [COL_W-1:0]  gen_mask_q;
    logic [BANK_W-1:0] gen_bank_q;
    logic [ROW_W-1:0]  gen_row_q;
    logic              gen_wr_q;
    logic              gen_ap_q;

    logic [2:0]        pv_q;
    logic [AW-1:0]     pa_q [3];
    logic [NL-1:0]     dqm1_q;
    logic [NL-1:0]     dqm2_q;

    cmd_e              cmd;
    logic              is_rw;
    logic              gen_busy;
    logic              gen_stop;
    logic              gen_cont;
    logic              iss_v;
    logic              iss_wr;
    logic [AW-1:0]     iss_addr;
    logic [COL_W-1:0]  new_mask;
    logic              mode_ok;

    function automatic logic [COL_W-1:0] bl_mask(input logic [2:0] code);
        case (code)
            3'd1:    bl_mask = COL_W'(1);
            3'd2:    bl_mask = COL_W'(3);
            3'd3:    bl_mask = COL_W'(7);
            3'd7:    bl_mask = '1;
            default: bl_mask = '0;
        endcase
    endfunction

    // Sequential increment that wraps inside the mask-aligned block
    function automatic logic [COL_W-1:0] wrap_col(input logic [COL_W-1:0] col,
                                                  input logic [COL_W-1:0] mask);
        logic [COL_W-1:0] inc;
        inc = col + COL_W'(1);
        wrap_col = (col & ~mask) | (inc & mask);
    endfunction

    always_comb begin
        cmd = CmdNop;
        if (!bus.cs) begin
            cmd = cmd_e'({bus.ras, bus.cas, bus.we});
        end
        is_rw    = (cmd == CmdRead) || (cmd == CmdWrite);
        gen_busy = (gen_left_q != '0);
        gen_stop = is_rw || (cmd == CmdTerminate) ||
                   ((cmd == CmdPrecharge) && (bus.a[10] || (bus.ba == gen_bank_q)));
        gen_cont = gen_busy && !gen_stop;
        new_mask = ((cmd == CmdWrite) && wb_single_q) ? '0 : bl_mask(bl_code_q);
        iss_v    = is_rw || gen_cont;
        iss_wr   = is_rw ? (cmd == CmdWrite) : gen_wr_q;
        iss_addr = is_rw ? {bus.ba, row_q[bus.ba], bus.a[COL_W-1:0]}
                         : {gen_bank_q, gen_row_q, gen_col_q};
        mode_ok  = (bus.a[2:0] inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd7}) &&
                   (bus.a[6:4] inside {3'd2, 3'd3});
    end

    // Array contents survive reset; masked lanes keep their old bytes
    always_ff @(posedge clk) begin
        if (!reset && bus.cke && iss_v && iss_wr) begin
            for (int l = 0; l < NL; l++) begin
                if (!bus.dqm[l]) begin
                    mem[iss_addr][l*8 +: 8] <= dq[l*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            open_q      <= '0;
            cl3_q       <= 1'b0;
            bl_code_q   <= 3'd0;
            wb_single_q <= 1'b0;
            gen_left_q  <= '0;
            gen_col_q   <= '0;
            gen_mask_q  <= '0;
            gen_bank_q  <= '0;
            gen_row_q   <= '0;
            gen_wr_q    <= 1'b0;
            gen_ap_q    <= 1'b0;
            pv_q        <= '0;
            pa_q[0]     <= '0;
            pa_q[1]     <= '0;
            pa_q[2]     <= '0;
            dqm1_q      <= '0;
            dqm2_q      <= '0;
        end else if (bus.cke) begin
            dqm1_q  <= bus.dqm;
            dqm2_q  <= dqm1_q;
            pv_q    <= {pv_q[1:0], iss_v && !iss_wr};
            pa_q[0] <= iss_addr;
            pa_q[1] <= pa_q[0];
            pa_q[2] <= pa_q[1];
            // A write turns the bus around at once, dropping pipelined read words
            if (cmd == CmdWrite) begin
                pv_q <= '0;
            end

            if (gen_cont) begin
                gen_left_q <= gen_left_q - COL_W'(1);
                gen_col_q  <= wrap_col(gen_col_q, gen_mask_q);
                if ((gen_left_q == COL_W'(1)) && gen_ap_q) begin
                    open_q[gen_bank_q] <= 1'b0;
                end
            end else if (gen_stop) begin
                gen_left_q <= '0;
                if (gen_busy && gen_ap_q) begin
                    open_q[gen_bank_q] <= 1'b0;
                end
            end

            unique case (cmd)
                CmdActive: begin
                    open_q[bus.ba] <= 1'b1;
                    row_q[bus.ba]  <= bus.a;
                end
                CmdPrecharge: begin
                    if (bus.a[10]) begin
                        open_q <= '0;
                    end else begin
                        open_q[bus.ba] <= 1'b0;
                    end
                end
                CmdRead, CmdWrite: begin
                    gen_left_q <= new_mask;
                    gen_col_q  <= wrap_col(bus.a[COL_W-1:0], new_mask);
                    gen_mask_q <= new_mask;
                    gen_bank_q <= bus.ba;
                    gen_row_q  <= row_q[bus.ba];
                    gen_wr_q   <= (cmd == CmdWrite);
                    gen_ap_q   <= bus.a[10];
                    // Single-word burst: its only word is also its last
                    if ((new_mask == '0) && bus.a[10]) begin
                        open_q[bus.ba] <= 1'b0;
                    end
                end
                CmdLoadMode: begin
                    if (mode_ok) begin
                        bl_code_q   <= bus.a[2:0];
                        cl3_q       <= bus.a[4];
                        wb_single_q <= bus.a[9];
                    end
                end
                default: ;
            endcase
        end
    end

    logic            out_v;
    logic [AW-1:0]   out_a;
    logic [DQ_W-1:0] out_d;

    assign out_v = cl3_q ? pv_q[2] : pv_q[1];
    assign out_a = cl3_q ? pa_q[2] : pa_q[1];
    assign out_d = mem[out_a];

    for (genvar l = 0; l < NL; l++) begin : g_lane
        assign dq[l*8 +: 8] = (out_v && !dqm2_q[l]) ? out_d[l*8 +: 8] : 8'hzz;
    end

`ifdef SDRAM_CHECK_EN
    logic              chk_hit;
    logic [BANK_W-1:0] chk_bank;
    logic              err_q;

    always_comb begin
        chk_hit  = 1'b0;
        chk_bank = bus.ba;
        unique case (cmd)
            CmdActive:         chk_hit = open_q[bus.ba];
            CmdRead, CmdWrite: chk_hit = !open_q[bus.ba];
            CmdRefresh:        chk_hit = |open_q;
            CmdLoadMode:       chk_hit = (|open_q) || !mode_ok;
            default: ;
        endcase
        if (iss_v && iss_wr) begin
            for (int l = 0; l < NL; l++) begin
                if (!bus.dqm[l] && $isunknown(dq[l*8 +: 8])) begin
                    chk_hit = 1'b1;
                end
            end
            if (!is_rw) begin
                chk_bank = gen_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bus.cke && chk_hit) begin
            err_q <= 1'b1;
            $display("%0t sdram_model_param: protocol error, cmd %s bank %0d",
                     $time, cmd.name(), chk_bank);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_model_param.sv
// Directed bench for sdram_model_param: bursts, CL, DQM, interrupts, suspend, reset, checker.
// Bus values are sampled on the falling edge, i.e. what the controller sees at the next rise.
module tb_sdram_model_param;
    localparam int unsigned DQ_W   = 16;
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned COL_W  = 9;
    localparam int unsigned BANK_W = 2;

    localparam logic [2:0] CmdLoadMode  = 3'b000;
    localparam logic [2:0] CmdPrecharge = 3'b010;
    localparam logic [2:0] CmdActive    = 3'b011;
    localparam logic [2:0] CmdWrite     = 3'b100;
    localparam logic [2:0] CmdRead      = 3'b101;
    localparam logic [2:0] CmdTerminate = 3'b110;

    logic            clk = 1'b0;
    logic            reset;
    logic [15:0]     tb_dq;
    logic            tb_oe;
    tri1  [DQ_W-1:0] dq;
    logic            err;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [15:0]     exp_w [16];
    logic [31:0]     exp_err;

    sdram_model_param_if #(.DQ_W(DQ_W), .ROW_W(ROW_W), .BANK_W(BANK_W)) bus_if ();

    assign dq = tb_oe ? tb_dq : 16'hzzzz;

    sdram_model_param #(
        .DQ_W  (DQ_W),
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .BANK_W(BANK_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if),
        .dq   (dq),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr);
        bus_if.cs = 1'b0;
        {bus_if.ras, bus_if.cas, bus_if.we} = c;
        bus_if.ba = b;
        bus_if.a  = addr;
    endtask

    task automatic set_nop();
        bus_if.cs = 1'b1;
        {bus_if.ras, bus_if.cas, bus_if.we} = 3'b111;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr);
        set_cmd(c, b, addr);
        step();
        set_nop();
    endtask

    task automatic write_burst(input logic [1:0] b, input logic [12:0] addr,
                               input logic [15:0] base, input int n);
        tb_oe = 1'b1;
        for (int k = 0; k < n; k++) begin
            tb_dq = base + 16'(k);
            if (k == 0) set_cmd(CmdWrite, b, addr);
            else        set_nop();
            step();
        end
        set_nop();
        tb_oe = 1'b0;
    endtask

    task automatic write_one(input logic [1:0] b, input logic [12:0] addr,
                             input logic [15:0] data, input logic [1:0] mask);
        tb_oe       = 1'b1;
        tb_dq       = data;
        bus_if.dqm  = mask;
        cmd(CmdWrite, b, addr);
        tb_oe       = 1'b0;
        bus_if.dqm  = 2'b00;
    endtask

    // Reads n words expected in exp_w, then expects a released bus
    task automatic read_chk(input string tag, input logic [1:0] b, input logic [12:0] addr,
                            input int n, input int cl);
        cmd(CmdRead, b, addr);
        repeat (cl - 1) step();
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_w%0d", tag, k), dq, exp_w[k]);
            step();
        end
        check_eq({tag, "_z"}, dq, 16'hFFFF);
    endtask

    initial begin
        reset      = 1'b1;
        tb_oe      = 1'b0;
        tb_dq      = 16'h0000;
        bus_if.cke = 1'b1;
        bus_if.dqm = 2'b00;
        bus_if.a   = '0;
        bus_if.ba  = '0;
        set_nop();
        repeat (3) step();
        check_eq("rst_dq", dq, 16'hFFFF);
        check_eq("rst_err", err, 32'd0);
        reset = 1'b0;
        step();

        // Power-up: CL2 BL8, burst written at 0x1FC wraps inside 0x1F8..0x1FF
        cmd(CmdLoadMode, 2'd0, 13'h023);
        cmd(CmdActive, 2'd1, 13'h0ABC);
        write_burst(2'd1, 13'h1FC, 16'h1000, 8);
        step();
        for (int k = 0; k < 8; k++) exp_w[k] = 16'h1000 + 16'(k);
        read_chk("pu", 2'd1, 13'h1FC, 8, 2);
        for (int k = 0; k < 8; k++) exp_w[k] = 16'h1000 + 16'((k + 4) % 8);
        read_chk("wrap", 2'd1, 13'h1F8, 8, 2);

        // CL3 BL4, single-word writes; dqm upper lane at READ+1
        cmd(CmdPrecharge, 2'd0, 13'h400);
        cmd(CmdLoadMode, 2'd0, 13'h232);
        cmd(CmdActive, 2'd1, 13'h0ABC);
        cmd(CmdRead, 2'd1, 13'h1FC);
        bus_if.dqm = 2'b10;
        step();
        bus_if.dqm = 2'b00;
        step();
        check_eq("cl3_w0", dq, 16'hFF00);
        step();
        check_eq("cl3_w1", dq, 16'h1001);
        step();
        check_eq("cl3_w2", dq, 16'h1002);
        step();
        check_eq("cl3_w3", dq, 16'h1003);
        step();
        check_eq("cl3_z7", dq, 16'hFFFF);

        // Byte-masked write on top of 0xFFFF
        write_one(2'd1, 13'h010, 16'hFFFF, 2'b00);
        write_one(2'd1, 13'h011, 16'h2222, 2'b00);
        write_one(2'd1, 13'h012, 16'h3333, 2'b00);
        write_one(2'd1, 13'h013, 16'h4444, 2'b00);
        write_one(2'd1, 13'h010, 16'h1234, 2'b01);
        exp_w[0] = 16'h12FF;
        exp_w[1] = 16'h2222;
        exp_w[2] = 16'h3333;
        exp_w[3] = 16'h4444;
        read_chk("wmask", 2'd1, 13'h010, 4, 3);

        // Read-to-read interrupt then terminate, CL2 BL8
        cmd(CmdPrecharge, 2'd0, 13'h400);
        cmd(CmdLoadMode, 2'd0, 13'h023);
        cmd(CmdActive, 2'd1, 13'h0ABC);
        write_burst(2'd1, 13'h000, 16'h2000, 8);
        write_burst(2'd1, 13'h040, 16'h2040, 8);
        step();
        cmd(CmdRead, 2'd1, 13'h000);
        step();
        check_eq("rr_w0", dq, 16'h2000);
        cmd(CmdRead, 2'd1, 13'h040);
        check_eq("rr_w1", dq, 16'h2001);
        step();
        check_eq("rr_w2", dq, 16'h2040);
        cmd(CmdTerminate, 2'd1, 13'h000);
        check_eq("rr_w3", dq, 16'h2041);
        step();
        check_eq("rr_z6", dq, 16'hFFFF);
        step();
        check_eq("rr_z7", dq, 16'hFFFF);

        // Auto-precharge read, then re-activate the same bank
        for (int k = 0; k < 8; k++) exp_w[k] = 16'h2000 + 16'(k);
        read_chk("ap", 2'd1, 13'h400, 8, 2);
        cmd(CmdActive, 2'd1, 13'h0ABC);
        check_eq("ap_act_err", err, 32'd0);

        // Clock suspend for three edges mid-burst
        cmd(CmdRead, 2'd1, 13'h000);
        step();
        check_eq("sus_w0", dq, 16'h2000);
        step();
        check_eq("sus_w1", dq, 16'h2001);
        bus_if.cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("sus_hold%0d", i), dq, 16'h2001);
        end
        bus_if.cke = 1'b1;
        for (int k = 2; k < 8; k++) begin
            step();
            check_eq($sformatf("sus_w%0d", k), dq, 16'h2000 + 16'(k));
        end
        step();
        check_eq("sus_z", dq, 16'hFFFF);

        // Read to a closed bank, then reset mid-burst
`ifdef SDRAM_CHECK_EN
        exp_err = 32'd1;
`else
        exp_err = 32'd0;
`endif
        cmd(CmdPrecharge, 2'd0, 13'h400);
        check_eq("chk_pre", err, 32'd0);
        cmd(CmdRead, 2'd2, 13'h000);
        check_eq("chk_err", err, exp_err);
        step();
        step();
        check_eq("chk_sticky", err, exp_err);
        reset = 1'b1;
        #1;
        check_eq("chk_rst_err", err, 32'd0);
        check_eq("rst_abort_dq", dq, 16'hFFFF);
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("rst_abort_idle", dq, 16'hFFFF);

        // Mode back to CL2 BL1; memory contents kept across reset
        cmd(CmdActive, 2'd1, 13'h0ABC);
        exp_w[0] = 16'h12FF;
        read_chk("rst_keep", 2'd1, 13'h010, 1, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
